pipeline_ctrl: RTL
==================

# pipeline_ctrl

Parametrised pipeline control unit for the OpenMIPS core. It merges per-stage stall requests into a prefix stall mask over `NSTAGE` stages. It also handles exception and `eret` flushes, producing `flush` and `new_pc`, and masks stale stall requests for a programmable window after each flush. It keeps a saturating stall-cycle performance counter and a sticky stall watchdog. It sits beside the pipeline registers (pc, if/id, id/ex, ex/mem, mem/wb) and drives their stall and flush controls.

## Interface
- `NSTAGE`, 6: number of pipeline stages. Stage 0 is pc, stage `NSTAGE-1` is wb.
- `ADDR_W`, 32: width of `new_pc` and `epc_in`.
- `EXC_VEC`, 32'h0000_0020: exception handler entry address.
- `SQUASH_CYC`, 2: number of cycles after a flush during which `stallreq[NSTAGE-1:1]` is ignored. Legal range 0..15.
- `CNT_W`, 32: width of the stall-cycle counter.
- `TIMEOUT`, 1024: number of consecutive stalled cycles that sets `stall_timeout`. Must be at least 1.

Ports:
- `clk`, input, 1: clock, rising edge.
- `rst`, input, 1: reset, synchronous, active-high.
- `stallreq`, input, `NSTAGE`: stall request. Bit i comes from stage i.
- `excp_valid`, input, 1: an exception is committed this cycle.
- `excp_eret`, input, 1: qualifies `excp_valid`. 1 means `eret`, which returns to `epc_in`.
- `epc_in`, input, `ADDR_W`: CP0 EPC value.
- `stat_clr`, input, 1: clears `stall_cnt` and `stall_timeout`.
- `stall`, output, `NSTAGE`: stall mask. Bit i holds stage i.
- `flush`, output, 1: clears all pipeline registers this cycle.
- `new_pc`, output, `ADDR_W`: redirect target. Valid only while `flush` is 1.
- `squash_active`, output, 1: high while the post-flush mask window is open.
- `stall_cnt`, output, `CNT_W`: number of cycles with `stall != 0`. Saturating.
- `stall_timeout`, output, 1: sticky watchdog flag.

## Operation
- **Effective requests.**
  - `eff_req = stallreq` in IDLE.
  - `eff_req = stallreq & 1` (only bit 0 kept) in SQUASH.
  - Requests from downstream stages during SQUASH come from squashed bubbles and are discarded.
- **Stall mask** (combinational). Let k be the highest set bit of `eff_req`. Then `stall = (1 << (k+1)) - 1`, i.e. stages 0..k are held. If no bit is set, `stall = 0`.
  - Examples with `NSTAGE=6`: a request from stage 2 gives `000111`; a request from stage 3 gives `001111`; both together give `001111`.
- **Exception priority.**
  - `excp_valid=1` forces `stall = 0` and `flush = 1` in the same cycle.
  - `new_pc = excp_eret ? epc_in : EXC_VEC`.
  - With `excp_valid=0`: `flush = 0` and `new_pc = 0`.
- **FSM.** States are IDLE and SQUASH, with a down-counter `sq_cnt` of 4 bits.
  - IDLE → SQUASH when `excp_valid` and `SQUASH_CYC > 0`. `sq_cnt` loads `SQUASH_CYC - 1`.
  - In SQUASH: if `sq_cnt == 0`, go to IDLE; otherwise decrement.
  - `excp_valid` during SQUASH is still honoured (flush, `new_pc`) and reloads `sq_cnt` to `SQUASH_CYC - 1`, restarting the window.
  - `squash_active = (state == SQUASH)`.
- **Stall counter.**
  - Increments each cycle in which `stall != 0`.
  - Saturates at all-ones.
  - `stat_clr` sets it to 0 and takes priority over increment.
- **Watchdog.**
  - `run_cnt` has width `$clog2(TIMEOUT+1)`. It increments while `stall != 0` and is cleared in any cycle with `stall == 0` or `flush`.
  - When `run_cnt` reaches `TIMEOUT`, `stall_timeout` is set and `run_cnt` holds.
  - `stall_timeout` is cleared only by `stat_clr` or `rst`.
- **Reset.** State IDLE, `sq_cnt = 0`, `stall_cnt = 0`, `run_cnt = 0`, `stall_timeout = 0`.
  - Combinational outputs are forced while `rst = 1`: `stall = 0`, `flush = 0`, `new_pc = 0`.
  - A reset during SQUASH returns to IDLE on the next edge.

## Timing
- `stall`, `flush` and `new_pc` are combinational from the inputs and the current state, with zero latency. This is required so that pipeline registers can hold in the same cycle.
- `squash_active`, `stall_cnt` and `stall_timeout` are registered and update on the rising edge after the triggering cycle.
- Exception in cycle T: `flush=1` in T; `squash_active=1` in T+1..T+`SQUASH_CYC`; `stallreq[NSTAGE-1:1]` is ignored over the same cycles.
- `stall_cnt` lags `stall` by one cycle.
- `stall_timeout` goes high at the edge ending the `TIMEOUT`-th consecutive stalled cycle.
- `stat_clr` together with the watchdog set condition: clear wins.

## Test plan
- **Reset.** Hold `rst` with `stallreq=6'b111111` and `excp_valid=1`. Required: `stall=0`, `flush=0`, `new_pc=0`, `stall_cnt=0`, `stall_timeout=0`.
- **Prefix encoding.** Drive `stallreq = 000100`, then `001000`, then `001100`, then `100000`. Required `stall`: `000111`, `001111`, `001111`, `111111` respectively. `stall_cnt` reads 4 one cycle after the last.
- **Exception priority.** Drive `stallreq=001000` with `excp_valid=1` and `excp_eret=0`. Required: `stall=0`, `flush=1`, `new_pc=32'h20`. In the next 2 cycles `stallreq=001000` gives `stall=0` and `squash_active=1`; in the third cycle `stall=001111`.
- **Eret.** Drive `excp_valid=1`, `excp_eret=1`, `epc_in=32'h0000_1234`. Required: `new_pc=32'h1234`. During the squash window, `stallreq=000001` still gives `stall=000001`.
- **Back-to-back exception.** Raise a second `excp_valid` on the first SQUASH cycle. Required: `flush=1` again, and `squash_active` stays high 2 cycles past the second exception.
- **Watchdog.** With `TIMEOUT=4`, hold `stallreq=000010` for 4 cycles. Required: `stall_timeout` rises after the 4th edge and stays high after `stallreq` drops. `stat_clr` clears `stall_timeout` and `stall_cnt`. Repeat with a saturation check on `stall_cnt` using `CNT_W=3`: it holds 7 after 10 stalled cycles.

Source files
------------

// File: rtl/pipeline_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : pipeline_ctrl
// Description : Pipeline control unit for the OpenMIPS core.
//               - Merges per-stage stall requests into a prefix stall mask.
//               - Drives flush and new_pc on exception / eret commit.
//               - Ignores downstream stall requests for a short window after
//                 each flush, because they come from squashed bubbles.
//               - Keeps a saturating stall-cycle counter and a sticky
//                 stall watchdog.
// Ports       : clk, rst           - clock (rising edge), sync active-high reset
//               stallreq[NSTAGE]   - stall request, bit i from stage i
//               excp_valid         - exception committed this cycle
//               excp_eret          - 1: eret (return to epc_in)
//               epc_in[ADDR_W]     - CP0 EPC value
//               stat_clr           - clears stall_cnt and stall_timeout
//               stall[NSTAGE]      - stall mask, bit i holds stage i (comb)
//               flush              - clear all pipeline registers (comb)
//               new_pc[ADDR_W]     - redirect target while flush=1 (comb)
//               squash_active      - post-flush mask window open (reg)
//               stall_cnt[CNT_W]   - saturating stalled-cycle count (reg)
//               stall_timeout      - sticky watchdog flag (reg)
// Revision    : 1.0 - initial release
// ============================================================================
module pipeline_ctrl #(
    parameter int              NSTAGE     = 6,
    parameter int              ADDR_W     = 32,
    parameter logic [ADDR_W-1:0] EXC_VEC  = 32'h0000_0020,
    parameter int              SQUASH_CYC = 2,
    parameter int              CNT_W      = 32,
    parameter int              TIMEOUT    = 1024
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NSTAGE-1:0] stallreq,
    input  logic              excp_valid,
    input  logic              excp_eret,
    input  logic [ADDR_W-1:0] epc_in,
    input  logic              stat_clr,
    output logic [NSTAGE-1:0] stall,
    output logic              flush,
    output logic [ADDR_W-1:0] new_pc,
    output logic              squash_active,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic              stall_timeout
);

    localparam int         c_RUN_W   = $clog2(TIMEOUT + 1);
    localparam logic [3:0] c_SQ_LOAD = (SQUASH_CYC > 0) ? 4'(SQUASH_CYC - 1) : 4'd0;
    localparam logic [c_RUN_W-1:0] c_TIMEOUT = c_RUN_W'(TIMEOUT);

    typedef enum logic [0:0] {
        S_IDLE   = 1'b0,
        S_SQUASH = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [3:0]         sq_cnt_q, sq_cnt_d;
    logic [CNT_W-1:0]   stall_cnt_q, stall_cnt_d;
    logic [c_RUN_W-1:0] run_cnt_q, run_cnt_d;
    logic               timeout_q, timeout_d;

    logic [NSTAGE-1:0]  w_eff_req;
    logic [NSTAGE-1:0]  w_mask;
    logic               w_any_stall;

    // ------------------------------------------------------------------
    // Stall mask, flush and redirect (zero-latency)
    // ------------------------------------------------------------------
    always_comb begin
        // During the squash window only the pc stage may still request.
        if (state_q == S_SQUASH) begin
            w_eff_req = {{(NSTAGE-1){1'b0}}, stallreq[0]};
        end else begin
            w_eff_req = stallreq;
        end
    end

    // Bit i is held if any stage at or downstream of i requests a stall.
    always_comb begin
        logic acc;
        acc    = 1'b0;
        w_mask = '0;
        for (int i = NSTAGE - 1; i >= 0; i--) begin
            acc       = acc | w_eff_req[i];
            w_mask[i] = acc;
        end
    end

    always_comb begin
        stall  = '0;
        flush  = 1'b0;
        new_pc = '0;
        if (!rst) begin
            if (excp_valid) begin
                flush  = 1'b1;
                new_pc = excp_eret ? epc_in : EXC_VEC;
            end else begin
                stall = w_mask;
            end
        end
    end

    assign w_any_stall = |stall;

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d  = state_q;
        sq_cnt_d = sq_cnt_q;
        if (excp_valid && (SQUASH_CYC > 0)) begin
            // A new exception (also inside the window) restarts the window.
            state_d  = S_SQUASH;
            sq_cnt_d = c_SQ_LOAD;
        end else if (state_q == S_SQUASH) begin
            if (sq_cnt_q == 4'd0) begin
                state_d = S_IDLE;
            end else begin
                sq_cnt_d = sq_cnt_q - 4'd1;
            end
        end
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (stat_clr) begin
            stall_cnt_d = '0;
        end else if (w_any_stall && !(&stall_cnt_q)) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end
    end

    always_comb begin
        run_cnt_d = run_cnt_q;
        if (flush || !w_any_stall) begin
            run_cnt_d = '0;
        end else if (run_cnt_q != c_TIMEOUT) begin
            run_cnt_d = run_cnt_q + 1'b1;
        end
    end

    // Set on the edge where the run reaches TIMEOUT; clear has priority.
    always_comb begin
        timeout_d = timeout_q;
        if (stat_clr) begin
            timeout_d = 1'b0;
        end else if (run_cnt_d == c_TIMEOUT) begin
            timeout_d = 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            sq_cnt_q    <= 4'd0;
            stall_cnt_q <= '0;
            run_cnt_q   <= '0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            sq_cnt_q    <= sq_cnt_d;
            stall_cnt_q <= stall_cnt_d;
            run_cnt_q   <= run_cnt_d;
            timeout_q   <= timeout_d;
        end
    end

    assign squash_active = (state_q == S_SQUASH);
    assign stall_cnt     = stall_cnt_q;
    assign stall_timeout = timeout_q;

endmodule
`default_nettype wire
